aom_dac_spi_tx: RTL and testbench

//  Receiving end of the AOM voltage update interface: accepts 1-cycle en/voltage strobes from the AOM

---
 rtl/aom_dac_spi_tx.sv | 208 ++++++++++++++++++++
 tb/tb_aom_dac_spi_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aom_dac_spi_tx.sv
// AOM DAC SPI transmitter: latest-wins update buffer feeding 16-bit SYNC_n/SCLK/DIN frames.
// Optional overload monitor enabled by defining AOM_OVERLOAD_MON_EN.
module aom_dac_spi_tx #(
   parameter int unsigned SCLK_DIV  = 4,
   parameter int unsigned CS_GAP    = 4,
   parameter logic [11:0] SAFE_CODE = 12'h000
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        aom_en_i,
   input  logic [11:0] aom_voltage_i,
   input  logic [11:0] aom_overload_vol_thre_i,
   input  logic [31:0] aom_overload_timeout_i,
   input  logic        fault_clr_i,
   output logic        busy_o,
   output logic        upd_drop_o,
   output logic [11:0] dac_cur_o,
   output logic        aom_fault_o,
   output logic        DAC_SYNC_N,
   output logic        DAC_SCLK,
   output logic        DAC_DIN
);

   localparam int unsigned PH_W = $clog2(2 * SCLK_DIV);
   localparam int unsigned GP_W = $clog2(CS_GAP + 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * SCLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_HIGH = PH_W'(SCLK_DIV);
   localparam logic [GP_W-1:0] GP_LAST = GP_W'(CS_GAP - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   state_t state_q, state_d;
   logic [PH_W-1:0] ph_q, ph_d;
   logic [3:0] bit_q, bit_d;
   logic [GP_W-1:0] gap_q, gap_d;
   logic [11:0] code_q, code_d;
   logic [11:0] pend_q, pend_d;
   logic pend_v_q, pend_v_d;
   logic [11:0] cur_q, cur_d;
   logic drop_q, drop_d;
   logic sync_n_q, sync_n_d;
   logic sclk_q, sclk_d;
   logic din_q, din_d;
   logic launch;
   logic [15:0] word_d;
   logic fault;
   logic trip;

`ifdef AOM_OVERLOAD_MON_EN
   logic [31:0] cnt_q, cnt_d;
   logic fault_q, fault_d;
   logic over;

   always_comb begin
      over = (cur_q > aom_overload_vol_thre_i) &&
             (aom_overload_timeout_i != 32'd0);
      cnt_d = 32'd0;
      if (over) begin
         cnt_d = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
      end
      // Only trips from the clear state, so a saturated count cannot re-arm it.
      trip = over && !fault_q && (cnt_d == aom_overload_timeout_i);
      fault_d = fault_q;
      if (trip) begin
         fault_d = 1'b1;
      end else if (fault_clr_i) begin
         fault_d = 1'b0;
         cnt_d = 32'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         fault_q <= fault_d;
      end
   end

   assign fault = fault_q;
`else
   logic unused_mon;
   assign unused_mon = ^{aom_overload_vol_thre_i, aom_overload_timeout_i, fault_clr_i};
   assign fault = 1'b0;
   assign trip = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ph_d = ph_q;
      bit_d = bit_q;
      gap_d = gap_q;
      code_d = code_q;
      pend_d = pend_q;
      pend_v_d = pend_v_q;
      cur_d = cur_q;
      drop_d = 1'b0;
      launch = 1'b0;

      if (aom_en_i) begin
         drop_d = fault | trip | pend_v_q;
         if (!(fault | trip)) begin
            pend_d = aom_voltage_i;
            pend_v_d = 1'b1;
         end
      end
      if (trip) begin
         pend_d = SAFE_CODE;
         pend_v_d = 1'b1;
      end

      unique case (state_q)
         IDLE: launch = pend_v_d;
         LOAD: begin
            state_d = SHIFT;
            ph_d = '0;
            bit_d = 4'd15;
         end
         SHIFT: begin
            if (ph_q == PH_LAST) begin
               ph_d = '0;
               if (bit_q == 4'd0) begin
                  state_d = GAP;
                  gap_d = '0;
                  cur_d = code_q;
               end else begin
                  bit_d = bit_q - 4'd1;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GP_LAST) begin
               state_d = IDLE;
               launch = pend_v_d;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         state_d = LOAD;
         code_d = pend_d;
         pend_v_d = 1'b0;
      end

      // Pin levels are registered from the next state to keep them glitch free.
      word_d = {2'b00, code_d, 2'b00};
      sync_n_d = !((state_d == LOAD) || (state_d == SHIFT));
      sclk_d = 1'b1;
      din_d = 1'b0;
      if (state_d == LOAD) begin
         din_d = word_d[15];
      end else if (state_d == SHIFT) begin
         sclk_d = (ph_d < PH_HIGH);
         din_d = word_d[bit_d];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         ph_q <= '0;
         bit_q <= 4'd0;
         gap_q <= '0;
         code_q <= 12'd0;
         pend_q <= 12'd0;
         pend_v_q <= 1'b0;
         cur_q <= 12'd0;
         drop_q <= 1'b0;
         sync_n_q <= 1'b1;
         sclk_q <= 1'b1;
         din_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q <= ph_d;
         bit_q <= bit_d;
         gap_q <= gap_d;
         code_q <= code_d;
         pend_q <= pend_d;
         pend_v_q <= pend_v_d;
         cur_q <= cur_d;
         drop_q <= drop_d;
         sync_n_q <= sync_n_d;
         sclk_q <= sclk_d;
         din_q <= din_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign upd_drop_o = drop_q;
   assign dac_cur_o = cur_q;
   assign aom_fault_o = fault;
   assign DAC_SYNC_N = sync_n_q;
   assign DAC_SCLK = sclk_q;
   assign DAC_DIN = din_q;

endmodule

// File: tb/tb_aom_dac_spi_tx.sv
// Bench for aom_dac_spi_tx: frame-timeline model checked every cycle plus literal frame checks.
// Overload scenarios run only when AOM_OVERLOAD_MON_EN is defined.
module tb_aom_dac_spi_tx;
   localparam int D = 4;
   localparam int G = 4;
   localparam int FL = 1 + 32 * D;
   localparam logic [11:0] SAFE = 12'h000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b0;
   logic clr = 1'b0;
   logic [11:0] vol = 12'h000;
   logic [11:0] thre = 12'hFFF;
   logic [31:0] tmo = 32'd0;
   logic busy, drop, fault, sync, sclk, din;
   logic [11:0] cur;

   always #5 clk = ~clk;

   aom_dac_spi_tx #(
      .SCLK_DIV(D),
      .CS_GAP(G),
      .SAFE_CODE(SAFE)
   ) dut (
      .clk_i(clk),
      .rst_n_i(rst_n),
      .aom_en_i(en),
      .aom_voltage_i(vol),
      .aom_overload_vol_thre_i(thre),
      .aom_overload_timeout_i(tmo),
      .fault_clr_i(clr),
      .busy_o(busy),
      .upd_drop_o(drop),
      .dac_cur_o(cur),
      .aom_fault_o(fault),
      .DAC_SYNC_N(sync),
      .DAC_SCLK(sclk),
      .DAC_DIN(din)
   );

   int total = 0;
   int bad = 0;

   // Model: a launched frame is a timeline indexed by cycles since launch.
   bit m_ok = 0, m_act = 0, m_pv = 0, m_drop = 0, m_fault = 0;
   int m_d = 0;
   logic [11:0] m_code = 12'h000, m_pend = 12'h000, m_cur = 12'h000;
   logic [31:0] m_cnt = 32'd0;

   always @(negedge clk) begin
      logic [15:0] w;
      logic e_sync, e_sclk, e_din, over, trip, nf;
      logic [17:0] ev, av;
      logic [31:0] cn;
      int j;
      if (m_ok) begin
         w = {2'b00, m_code, 2'b00};
         e_sync = 1'b1; e_sclk = 1'b1; e_din = 1'b0;
         if (m_act && m_d < FL) begin
            e_sync = 1'b0;
            if (m_d == 0) e_din = w[15];
            else begin
               j = m_d - 1;
               e_sclk = ((j % (2 * D)) < D);
               e_din = w[15 - j / (2 * D)];
            end
         end
         ev = {e_sync, e_sclk, e_din, m_act, m_drop, m_fault, m_cur};
         av = {sync, sclk, din, busy, drop, fault, cur};
         total++;
         if (av !== ev) begin
            bad++;
            $display("FAIL cycle t=%0t: got %h want %h", $time, av, ev);
         end
      end
      // Advance the model over the coming edge using the inputs it will sample.
      if (!rst_n) begin
         m_ok = 1; m_act = 0; m_pv = 0; m_drop = 0; m_fault = 0;
         m_cur = 12'h000; m_cnt = 32'd0; m_d = 0;
      end else begin
         m_drop = 0;
         trip = 1'b0; nf = 1'b0; cn = 32'd0;
`ifdef AOM_OVERLOAD_MON_EN
         over = (m_cur > thre) && (tmo != 0);
         if (over) cn = (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
         trip = over && !m_fault && (cn == tmo);
         if (clr && !trip) cn = 32'd0;
         nf = trip | (m_fault & !clr);
`else
         over = 1'b0;
`endif
         if (en) begin
            if (m_fault || trip || m_pv) m_drop = 1;
            if (!m_fault && !trip) begin m_pv = 1; m_pend = vol; end
         end
         if (trip) begin m_pv = 1; m_pend = SAFE; end
         m_fault = nf;
         m_cnt = cn;
         if (m_act) begin
            m_d++;
            if (m_d == FL) m_cur = m_code;
            if (m_d == FL + G) m_act = 0;
         end
         if (!m_act && m_pv) begin
            m_act = 1; m_d = 0; m_code = m_pend; m_pv = 0;
         end
      end
   end

   // Pin-level frame capture: bits sampled at SCLK fall while SYNC_N is low.
   logic prev_sync = 1'b1, prev_sclk = 1'b1;
   logic [15:0] sh = 16'h0;
   int nb = 0, lowc = 0, highc = 0, last_gap = -1, drops = 0, low_total = 0;
   logic [15:0] fw[$];
   int fb[$];
   int fl[$];

   always @(negedge clk) begin
      if (m_ok) begin
         if (drop) drops++;
         if (!sync && prev_sync) begin
            last_gap = highc; lowc = 0; nb = 0; sh = 16'h0;
         end
         if (!sync) begin
            lowc++; low_total++;
            if (prev_sclk && !sclk) begin sh = {sh[14:0], din}; nb++; end
         end else begin
            highc = prev_sync ? highc + 1 : 1;
         end
         if (sync && !prev_sync) begin
            fw.push_back(sh); fb.push_back(nb); fl.push_back(lowc);
         end
         prev_sync = sync;
         prev_sclk = sclk;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic strobe(input logic [11:0] v);
      en = 1'b1; vol = v;
      tick(1);
      en = 1'b0;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic wait_frames(input int tgt, input int budget);
      int c = 0;
      while (fw.size() < tgt && c < budget) begin tick(1); c++; end
      chk("frame_wait", fw.size(), tgt);
   endtask

   initial begin
      int n, d0, lt, c;
      rst_n = 1'b0; tick(3); rst_n = 1'b1; tick(2);
      chk("rst_sync", sync, 1); chk("rst_sclk", sclk, 1);
      chk("rst_busy", busy, 0); chk("rst_cur", cur, 0);

      n = fw.size();
      strobe(12'hABC);
      chk("t1_sync_low", sync, 0);
      wait_frames(n + 1, 400);
      chk("t1_word", fw[n], 16'h2AF0);
      chk("t1_bits", fb[n], 16);
      chk("t1_len", fl[n], 129);
      tick(2);
      chk("t1_cur", cur, 12'hABC);

      tick(10);
      n = fw.size(); d0 = drops;
      strobe(12'h100); tick(20);
      strobe(12'h200); tick(20);
      strobe(12'h300);
      wait_frames(n + 2, 600);
      chk("t2_word0", fw[n], 16'h0400);
      chk("t2_word1", fw[n + 1], 16'h0C00);
      chk("t2_drops", drops - d0, 1);
      chk("t2_gap", last_gap, G);
      tick(2);
      chk("t2_cur", cur, 12'h300);

      tick(10);
      strobe(12'h5A5);
      tick(66);
      rst_n = 1'b0; tick(1);
      chk("t3_sync", sync, 1); chk("t3_sclk", sclk, 1);
      chk("t3_cur", cur, 0); chk("t3_busy", busy, 0);
      rst_n = 1'b1;
      lt = low_total;
      tick(300);
      chk("t3_no_frame", low_total - lt, 0);
      chk("t3_cur_hold", cur, 0);

      tick(5);
      n = fw.size(); d0 = drops;
      strobe(12'h111);
      tick(FL + G - 1);
      strobe(12'h222);
      chk("t6_sync_low", sync, 0);
      wait_frames(n + 2, 600);
      chk("t6_word0", fw[n], 16'h0444);
      chk("t6_word1", fw[n + 1], 16'h0888);
      chk("t6_gap", last_gap, G);
      chk("t6_drops", drops - d0, 0);

`ifdef AOM_OVERLOAD_MON_EN
      tick(10);
      thre = 12'h800; tmo = 32'd10;
      n = fw.size();
      strobe(12'h900);
      c = 0;
      while (cur != 12'h900 && c < 400) begin tick(1); c++; end
      chk("t4_commit", cur, 12'h900);
      c = 0;
      while (!fault && c < 50) begin tick(1); c++; end
      chk("t4_trip_delay", c, 10);
      wait_frames(n + 2, 400);
      chk("t4_safe_word", fw[n + 1], 16'h0000);
      tick(10);
      chk("t4_safe_cur", cur, 0);
      d0 = drops;
      strobe(12'h123);
      tick(200);
      chk("t4_rej_drop", drops - d0, 1);
      chk("t4_rej_frames", fw.size(), n + 2);
      chk("t4_fault_held", fault, 1);
      clr = 1'b1; tick(1); clr = 1'b0;
      chk("t4_cleared", fault, 0);
      strobe(12'h123);
      wait_frames(n + 3, 400);
      chk("t4_after_clr", fw[n + 2], 16'h048C);

      tick(10);
      tmo = 32'd0;
      strobe(12'hFFF);
      tick(1000);
      chk("t5_no_fault", fault, 0);
      chk("t5_cur", cur, 12'hFFF);
`endif

      tick(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
